// File: rtl/cam_pixel_reader.sv
// Camera byte-stream capture: synchronizes the camera bus, pairs bytes into RGB565
// pixels and writes one frame into the frame buffer, then holds until reset.
module cam_pixel_reader #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              select,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              pixel_vsync,
  output logic              frame_short
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS * V_LINES - 1);

  typedef enum logic [1:0] {
    S_WAIT_VS_HI,
    S_WAIT_VS_LO,
    S_CAPTURE,
    S_DONE
  } state_t;

  // [0],[1] are the synchronizer stages, [2] is the previous synced value
  logic [2:0]        pclk_s_q,  pclk_s_d;
  logic [2:0]        vsync_s_q, vsync_s_d;
  logic [2:0]        href_s_q,  href_s_d;
  logic [7:0]        data_s1_q, data_s1_d;
  logic [7:0]        data_s2_q, data_s2_d;

  state_t            state_q,    state_d;
  logic              phase_q,    phase_d;
  logic [7:0]        hi_q,       hi_d;
  logic              wr_en_q,    wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [15:0]       wr_data_q,  wr_data_d;
  logic              pix_vs_q,   pix_vs_d;
  logic              short_q,    short_d;
  logic              full_q,     full_d;
  logic              end_pend_q, end_pend_d;

  logic pclk_evt, vs, vs_rise, href, href_fall, wr_go, written_all;

  always_comb begin
    pclk_s_d  = {pclk_s_q[1:0],  cam_pclk};
    vsync_s_d = {vsync_s_q[1:0], cam_vsync};
    href_s_d  = {href_s_q[1:0],  cam_href};
    data_s1_d = cam_data;
    data_s2_d = data_s1_q;

    pclk_evt  = pclk_s_q[1] & ~pclk_s_q[2];
    vs        = vsync_s_q[1];
    vs_rise   = vsync_s_q[1] & ~vsync_s_q[2];
    href      = href_s_q[1];
    href_fall = ~href_s_q[1] & href_s_q[2];

    wr_go       = wr_en_q & ~select;
    // A strobe in flight at the last address counts as a completed write
    written_all = full_q | (wr_go & (wr_addr_q == LAST_ADDR));

    state_d    = state_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    pix_vs_d   = 1'b0;
    short_d    = short_q;
    full_d     = full_q;
    end_pend_d = 1'b0;

    if (wr_go) begin
      if (wr_addr_q == LAST_ADDR) full_d = 1'b1;
      else                        wr_addr_d = wr_addr_q + 1'b1;
    end

    case (state_q)
      S_WAIT_VS_HI: if (vs) state_d = S_WAIT_VS_LO;
      S_WAIT_VS_LO: begin
        if (!vs) begin
          state_d   = S_CAPTURE;
          wr_addr_d = '0;
          phase_d   = 1'b0;
          short_d   = 1'b0;
          full_d    = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (end_pend_q) begin
          pix_vs_d = 1'b1;
          short_d  = ~written_all;
          state_d  = S_DONE;
        end else begin
          if (pclk_evt && href) begin
            if (!phase_q) begin
              hi_d = data_s2_q;
            end else if (!full_q) begin
              wr_en_d   = 1'b1;
              wr_data_d = {hi_q, data_s2_q};
            end
            phase_d = ~phase_q;
          end else if (href_fall) begin
            phase_d = 1'b0;
          end
          // A write latched in the same cycle as vsync rise goes out first
          if (vs_rise) begin
            if (wr_en_d) begin
              end_pend_d = 1'b1;
            end else begin
              pix_vs_d = 1'b1;
              short_d  = ~written_all;
              state_d  = S_DONE;
            end
          end
        end
      end
      default: ;
    endcase

    if (select) begin
      wr_en_d    = 1'b0;
      pix_vs_d   = 1'b0;
      end_pend_d = 1'b0;
      state_d    = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pclk_s_q   <= '0;
      vsync_s_q  <= '0;
      href_s_q   <= '0;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      state_q    <= S_WAIT_VS_HI;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      pix_vs_q   <= 1'b0;
      short_q    <= 1'b0;
      full_q     <= 1'b0;
      end_pend_q <= 1'b0;
    end else begin
      pclk_s_q   <= pclk_s_d;
      vsync_s_q  <= vsync_s_d;
      href_s_q   <= href_s_d;
      data_s1_q  <= data_s1_d;
      data_s2_q  <= data_s2_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      pix_vs_q   <= pix_vs_d;
      short_q    <= short_d;
      full_q     <= full_d;
      end_pend_q <= end_pend_d;
    end
  end

  assign wr_en       = wr_en_q & ~select;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign pixel_vsync = pix_vs_q;
  assign frame_short = short_q;

endmodule

// File: tb/tb_cam_pixel_reader.sv
// Randomized bench for cam_pixel_reader: expected writes are built from the byte
// stream by pairing bytes within each line and keeping the first H*V pixels.
module tb_cam_pixel_reader;
  localparam int H = 4, V = 2, AW = 3, NPIX = H * V;

  logic clk = 1'b0;
  logic reset, cam_pclk, cam_vsync, cam_href, select;
  logic [7:0] cam_data;
  logic wr_en, pixel_vsync, frame_short;
  logic [AW-1:0] wr_addr;
  logic [15:0] wr_data;

  always #5 clk = ~clk;

  cam_pixel_reader #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .select(select),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pixel_vsync(pixel_vsync), .frame_short(frame_short)
  );

  int n_chk = 0, n_pass = 0;
  logic [18:0] got_q[$];
  logic [18:0] exp_q[$];
  int pvs_cnt = 0, overlap_cnt = 0;
  bit exp_short;
  logic [7:0] line_b[4][10];
  int line_n[4];

  always @(negedge clk) begin
    if (wr_en) got_q.push_back({wr_addr, wr_data});
    if (pixel_vsync) pvs_cnt++;
    if (wr_en && pixel_vsync) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit vs_rise);
    cam_pclk = 1'b0;
    cam_data = b;
    tick(2);
    cam_pclk = 1'b1;
    if (vs_rise) cam_vsync = 1'b1;
    tick(2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b0);
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    idle(3);
    cam_vsync = 1'b0;
    idle(3);
  endtask

  task automatic send_lines(input int nl, input bit coincide);
    for (int l = 0; l < nl; l++) begin
      cam_href = 1'b1;
      for (int i = 0; i < line_n[l]; i++)
        send_byte(line_b[l][i], coincide && l == nl - 1 && i == line_n[l] - 1);
      cam_href = 1'b0;
      idle(2);
    end
  endtask

  task automatic end_frame();
    cam_vsync = 1'b1;
    idle(3);
    cam_vsync = 1'b0;
    idle(2);
  endtask

  task automatic fill_lines(input int nl, input bit seq);
    for (int l = 0; l < nl; l++)
      for (int i = 0; i < line_n[l]; i++)
        line_b[l][i] = seq ? 8'(16 + l * 8 + i) : 8'($urandom);
  endtask

  task automatic build_exp(input int nl);
    int pix = 0;
    exp_q.delete();
    for (int l = 0; l < nl; l++)
      for (int k = 0; k < line_n[l] / 2; k++) begin
        if (pix < NPIX) exp_q.push_back({AW'(pix), line_b[l][2*k], line_b[l][2*k+1]});
        pix++;
      end
    exp_short = (pix < NPIX);
  endtask

  task automatic compare_writes(input string tag, input int base);
    check({tag, "_nwr"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size()) check({tag, "_wr"}, got_q[base + i], exp_q[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic full_frame(input string tag, input int nl, input bit coincide);
    int b0, p0;
    build_exp(nl);
    b0 = got_q.size();
    p0 = pvs_cnt;
    vsync_pulse();
    send_lines(nl, coincide);
    end_frame();
    tick(8);
    compare_writes(tag, b0);
    check({tag, "_pvs"}, pvs_cnt - p0, 1);
    check({tag, "_short"}, frame_short, exp_short);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_pvs"}, pixel_vsync, 0);
    check({tag, "_short"}, frame_short, 0);
  endtask

  initial begin
    int b0, p0, nl;
    reset = 1'b0; cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
    cam_data = '0; select = 1'b0;
    #3;
    check_reset_outputs("rst0");
    tick(2);
    reset = 1'b1;
    tick(1);

    // nominal frame with sequential bytes, then a frame after done
    line_n[0] = 8; line_n[1] = 8;
    fill_lines(2, 1'b1);
    full_frame("nom", 2, 1'b0);
    b0 = got_q.size(); p0 = pvs_cnt;
    vsync_pulse(); send_lines(2, 1'b0); end_frame(); tick(8);
    check("done_nwr", got_q.size() - b0, 0);
    check("done_pvs", pvs_cnt - p0, 0);

    do_reset();
    line_n[0] = 8;
    fill_lines(1, 1'b0);
    full_frame("short", 1, 1'b0);

    do_reset();
    line_n[0] = 8; line_n[1] = 9; line_n[2] = 8;
    fill_lines(3, 1'b0);
    full_frame("ovf", 3, 1'b0);
    check("ovf_addr", wr_addr, 7);

    do_reset();
    line_n[0] = 8; line_n[1] = 8;
    fill_lines(2, 1'b0);
    full_frame("coin", 2, 1'b1);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) line_n[l] = $urandom_range(6, 9);
      fill_lines(nl, 1'b0);
      full_frame("rnd", nl, 1'($urandom));
    end

    // reset in the middle of a line
    do_reset();
    line_n[0] = 8; line_n[1] = 8;
    fill_lines(2, 1'b0);
    vsync_pulse();
    cam_href = 1'b1;
    b0 = got_q.size();
    for (int i = 0; i < 6; i++) send_byte(line_b[0][i], 1'b0);
    tick(4);
    check("rst_pre_nwr", got_q.size() - b0, 3);
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst_mid");
    idle(2);
    reset = 1'b1;
    b0 = got_q.size();
    idle(4);
    cam_href = 1'b0;
    idle(2);
    send_lines(2, 1'b0);
    check("rst_nowr", got_q.size() - b0, 0);
    fill_lines(2, 1'b0);
    full_frame("rst_next", 2, 1'b0);

    // select abort after two writes
    do_reset();
    line_n[0] = 8; line_n[1] = 8;
    fill_lines(2, 1'b0);
    build_exp(2);
    b0 = got_q.size(); p0 = pvs_cnt;
    vsync_pulse();
    cam_href = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(line_b[0][i], 1'b0);
    tick(4);
    select = 1'b1;
    for (int i = 4; i < 8; i++) send_byte(line_b[0][i], 1'b0);
    cam_href = 1'b0;
    idle(2);
    end_frame();
    tick(8);
    check("sel_nwr", got_q.size() - b0, 2);
    for (int i = 0; i < 2; i++)
      if (b0 + i < got_q.size()) check("sel_wr", got_q[b0 + i], exp_q[i]);
    check("sel_pvs", pvs_cnt - p0, 0);
    select = 1'b0;
    tick(2);
    vsync_pulse(); send_lines(2, 1'b0); end_frame(); tick(8);
    check("sel_hold_nwr", got_q.size() - b0, 2);
    check("sel_hold_pvs", pvs_cnt - p0, 0);

    check("overlap", overlap_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cam_pixel_reader.md
CAM_PIXEL_READER -- requirements
Module: cam_pixel_reader

Interface
REQ-001 Parameter H_PIXELS, default 640, pixels per line.
REQ-002 Parameter V_LINES, default 480, lines per frame.
REQ-003 Parameter ADDR_W, default 19, frame-buffer address width; H_PIXELS*V_LINES SHALL be at most 2^ADDR_W.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cam_pclk  input  1  camera pixel clock, asynchronous; sampled as data.
REQ-007 cam_vsync  input  1  camera frame sync; high pulse between frames.
REQ-008 cam_href  input  1  camera line valid.
REQ-009 cam_data  input  8  camera byte bus.
REQ-010 select  input  1  from the buffer controller; 1 = buffer frozen for readout, no writes.
REQ-011 wr_en  output  1  one-cycle frame-buffer write strobe.
REQ-012 wr_addr  output  ADDR_W  write address.
REQ-013 wr_data  output  16  RGB565 pixel, first camera byte in [15:8].
REQ-014 pixel_vsync  output  1  one-cycle pulse when one complete frame has been written.
REQ-015 frame_short  output  1  sticky; last frame ended with fewer than H_PIXELS*V_LINES pixels.

Function
REQ-016 cam_pclk, cam_vsync, cam_href and cam_data SHALL each pass through a 2-flop synchronizer; all logic uses only the synchronized copies.
REQ-017 A pclk event is the cycle in which synced pclk = 1 and its previous-cycle value = 0.
REQ-018 FSM states are S_WAIT_VS_HI, S_WAIT_VS_LO, S_CAPTURE and S_DONE; the reset state is S_WAIT_VS_HI.
REQ-019 S_WAIT_VS_HI -> S_WAIT_VS_LO when synced vsync = 1.
  - This discards any partial frame that is in progress at reset release.
REQ-020 S_WAIT_VS_LO -> S_CAPTURE when synced vsync = 0.
  - On this transition: wr_addr <= 0, byte phase <= 0, frame_short <= 0.
REQ-021 In S_CAPTURE, on a pclk event with synced href = 1, the synced cam_data byte is latched.
  - Phase 0: latch into the high byte.
  - Phase 1: latch into the low byte.
  - The phase toggles after each latch.
REQ-022 In S_CAPTURE, a phase-1 latch SHALL produce the following on the next cycle:
  - wr_en = 1 for exactly one cycle;
  - wr_data = {high, low};
  - wr_addr = the current pixel index.
  - wr_addr increments in the cycle after the strobe.
REQ-023 A synced href falling edge SHALL force byte phase to 0; an odd trailing byte is dropped.
REQ-024 When wr_addr = H_PIXELS*V_LINES-1 and a write completes, wr_addr SHALL hold (saturate).
  - Further pixels in the same frame produce no wr_en.
REQ-025 In S_CAPTURE, synced vsync rising SHALL end the frame:
  - pixel_vsync = 1 for exactly one cycle;
  - the FSM moves to S_DONE.
REQ-026 At frame end, frame_short SHALL be set if fewer than H_PIXELS*V_LINES writes occurred; otherwise it stays 0.
REQ-027 If vsync rises in the same cycle that a write strobe is pending, the write SHALL complete first; pixel_vsync then follows one cycle later.
REQ-028 S_DONE SHALL be held until reset, with no writes and no further pixel_vsync pulses.
REQ-029 When select = 1, wr_en SHALL be forced low in every state.
  - If select = 1 in any state other than S_DONE, the FSM SHALL move to S_DONE without pulsing pixel_vsync.
REQ-030 pixel_vsync and wr_en SHALL never be high in the same cycle.

Reset
REQ-031 Assertion of reset SHALL immediately produce, regardless of clk:
  - wr_en = 0, wr_addr = 0, wr_data = 0;
  - pixel_vsync = 0, frame_short = 0;
  - byte phase = 0, synchronizer flops = 0;
  - state = S_WAIT_VS_HI.
REQ-032 Reset asserted mid-frame SHALL abandon that frame.
  - After release, capture restarts only after a full vsync high-then-low sequence.

Verification (bench uses H_PIXELS=4, V_LINES=2, ADDR_W=3, pclk = clk/4)
REQ-033 Nominal frame:
  - Stimulus: vsync pulse, then 2 lines of 8 bytes 0x10..0x1F, then vsync rise.
  - Response: 8 writes at addresses 0..7 with data 0x1011, 0x1213, ... 0x1E1F.
  - Then pixel_vsync pulses once, frame_short = 0, and no further writes.
REQ-034 Short frame:
  - Stimulus: only 1 line (4 pixels) before vsync rise.
  - Response: writes at addresses 0..3, then pixel_vsync pulses and frame_short = 1.
REQ-035 Overflow and odd byte:
  - Stimulus: 3 lines of 8 bytes, one of which carries an extra 9th byte.
  - Response: exactly 8 writes, wr_addr saturates at 7, the odd byte is dropped, and frame_short = 0.
REQ-036 Reset mid-frame:
  - Stimulus: assert reset after 3 writes; release while vsync is low and href is active.
  - Response: no writes until a vsync high-low sequence occurs, then the next frame is captured from address 0.
REQ-037 select abort:
  - Stimulus: drive select = 1 after 2 writes.
  - Response: wr_en stays 0 from then on, pixel_vsync never pulses, and the FSM holds S_DONE until reset.
REQ-038 Second frame after done:
  - Stimulus: apply another full frame after pixel_vsync.
  - Response: zero writes and no second pixel_vsync pulse.
